// File: rtl/rb_port_arbiter.sv
// rb_port_arbiter
// Shares the register bank's two combinational read ports and its single
// write port among NUM_REQ requesters (issue slots, writeback units).
//   - Writes: round-robin on wr_rr_q; the grantee's mask/addr/data go to the bank.
//   - Reads:  round-robin on rd_rr_q.
//       * The first eligible requester P takes port 0.
//       * If P needs two operands it also takes port 1.
//       * Otherwise the next eligible single-operand requester Q takes port 1.
//   - A read whose source matches the address written this cycle is held off
//     one cycle, so it always observes post-write data.
//   - Read data is registered one cycle after the handshake and tagged with the id.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rd_valid/rd_ready/rd_two     read request, combinational grant, two-operand flag
//   rd_addr_a/rd_addr_b/rd_mask  per-requester source addresses and lane mask
//   wr_valid/wr_ready            write request and combinational grant
//   wr_addr/wr_mask/wr_data      per-requester write address, lane mask and data
//   read_en_*/raddr_*/rdata_*    bank read ports
//   write_en/waddr/wdata         bank write port
//   resp*_valid/_id/_data        registered read responses, one per read port
module rb_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_LANES = 16,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    rd_valid,
    output logic [NUM_REQ-1:0]                    rd_ready,
    input  logic [NUM_REQ-1:0]                    rd_two,
    input  logic [NUM_REQ*ADDR_W-1:0]             rd_addr_a,
    input  logic [NUM_REQ*ADDR_W-1:0]             rd_addr_b,
    input  logic [NUM_REQ*NUM_LANES-1:0]          rd_mask,
    input  logic [NUM_REQ-1:0]                    wr_valid,
    output logic [NUM_REQ-1:0]                    wr_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]             wr_addr,
    input  logic [NUM_REQ*NUM_LANES-1:0]          wr_mask,
    input  logic [NUM_REQ*NUM_LANES*DATA_W-1:0]   wr_data,
    output logic [NUM_LANES-1:0]                  read_en_0,
    output logic [NUM_LANES-1:0]                  read_en_1,
    output logic [ADDR_W-1:0]                     raddr_0,
    output logic [ADDR_W-1:0]                     raddr_1,
    input  logic [NUM_LANES*DATA_W-1:0]           rdata_0,
    input  logic [NUM_LANES*DATA_W-1:0]           rdata_1,
    output logic [NUM_LANES-1:0]                  write_en,
    output logic [ADDR_W-1:0]                     waddr,
    output logic [NUM_LANES*DATA_W-1:0]           wdata,
    output logic                                  resp0_valid,
    output logic                                  resp1_valid,
    output logic [$clog2(NUM_REQ)-1:0]            resp0_id,
    output logic [$clog2(NUM_REQ)-1:0]            resp1_id,
    output logic [NUM_LANES*DATA_W-1:0]           resp0_data,
    output logic [NUM_LANES*DATA_W-1:0]           resp1_data
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int VEC_W = NUM_LANES * DATA_W;

    // Requester index arithmetic wraps naturally because NUM_REQ is a power of 2.
    function automatic logic [ID_W-1:0] id_add(input logic [ID_W-1:0] base, input int offs);
        logic [31:0] offs_v;
        offs_v = offs;
        return base + offs_v[ID_W-1:0];
    endfunction

    logic [ID_W-1:0]   wr_rr_q, wr_rr_d;
    logic [ID_W-1:0]   rd_rr_q, rd_rr_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [ID_W-1:0]   resp0_id_q, resp0_id_d;
    logic [ID_W-1:0]   resp1_id_q, resp1_id_d;
    logic [VEC_W-1:0]  resp0_data_q, resp0_data_d;
    logic [VEC_W-1:0]  resp1_data_q, resp1_data_d;

    logic              wr_hit_s;
    logic              wr_go_s;
    logic [ID_W-1:0]   wr_gnt_s;
    logic [NUM_REQ-1:0] rd_elig_s;
    logic              p_hit_s;
    logic [ID_W-1:0]   p_id_s;
    logic              q_hit_s;
    logic [ID_W-1:0]   q_id_s;
    logic              p1_use_s;
    logic [ID_W-1:0]   p1_id_s;

    // Write arbiter: first wr_valid requester scanning upward from wr_rr_q.
    always_comb begin
        wr_hit_s = 1'b0;
        wr_gnt_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!wr_hit_s && wr_valid[id_add(wr_rr_q, i)]) begin
                wr_hit_s = 1'b1;
                wr_gnt_s = id_add(wr_rr_q, i);
            end else begin
                wr_hit_s = wr_hit_s;
            end
        end
        wr_go_s = wr_hit_s & ~rst;
    end

    // Write port drive: the grantee's controls, or all zero when idle.
    always_comb begin
        wr_ready = '0;
        write_en = '0;
        waddr    = '0;
        wdata    = '0;
        if (wr_go_s) begin
            wr_ready[wr_gnt_s] = 1'b1;
            write_en = wr_mask[int'(wr_gnt_s)*NUM_LANES +: NUM_LANES];
            waddr    = wr_addr[int'(wr_gnt_s)*ADDR_W +: ADDR_W];
            wdata    = wr_data[int'(wr_gnt_s)*VEC_W +: VEC_W];
        end else begin
            wr_ready = '0;
        end
    end

    // Read eligibility: a source matching this cycle's write address waits a
    // cycle so it sees the new value (address compare only, masks ignored).
    always_comb begin
        rd_elig_s = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rd_elig_s[r] = rd_valid[r] & ~rst
                         & ~(wr_go_s & (rd_addr_a[r*ADDR_W +: ADDR_W] == waddr))
                         & ~(wr_go_s & rd_two[r] & (rd_addr_b[r*ADDR_W +: ADDR_W] == waddr));
        end
    end

    // Read arbiter: P from rd_rr_q; Q is the next single-operand requester
    // after P, considered only when P leaves port 1 free.
    always_comb begin
        p_hit_s = 1'b0;
        p_id_s  = '0;
        q_hit_s = 1'b0;
        q_id_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!p_hit_s && rd_elig_s[id_add(rd_rr_q, i)]) begin
                p_hit_s = 1'b1;
                p_id_s  = id_add(rd_rr_q, i);
            end else begin
                p_hit_s = p_hit_s;
            end
        end
        for (int j = 1; j < NUM_REQ; j++) begin
            if (p_hit_s && !rd_two[p_id_s] && !q_hit_s
                && rd_elig_s[id_add(p_id_s, j)] && !rd_two[id_add(p_id_s, j)]) begin
                q_hit_s = 1'b1;
                q_id_s  = id_add(p_id_s, j);
            end else begin
                q_hit_s = q_hit_s;
            end
        end
    end

    // Read port drive: port 0 always serves P; port 1 serves P's B operand or Q.
    always_comb begin
        rd_ready  = '0;
        read_en_0 = '0;
        read_en_1 = '0;
        raddr_0   = '0;
        raddr_1   = '0;
        p1_use_s  = 1'b0;
        p1_id_s   = '0;
        if (p_hit_s) begin
            rd_ready[p_id_s] = 1'b1;
            read_en_0 = rd_mask[int'(p_id_s)*NUM_LANES +: NUM_LANES];
            raddr_0   = rd_addr_a[int'(p_id_s)*ADDR_W +: ADDR_W];
            if (rd_two[p_id_s]) begin
                read_en_1 = rd_mask[int'(p_id_s)*NUM_LANES +: NUM_LANES];
                raddr_1   = rd_addr_b[int'(p_id_s)*ADDR_W +: ADDR_W];
                p1_use_s  = 1'b1;
                p1_id_s   = p_id_s;
            end else if (q_hit_s) begin
                rd_ready[q_id_s] = 1'b1;
                read_en_1 = rd_mask[int'(q_id_s)*NUM_LANES +: NUM_LANES];
                raddr_1   = rd_addr_a[int'(q_id_s)*ADDR_W +: ADDR_W];
                p1_use_s  = 1'b1;
                p1_id_s   = q_id_s;
            end else begin
                p1_use_s  = 1'b0;
            end
        end else begin
            p1_use_s = 1'b0;
        end
    end

    // Next state: pointers advance past the winner; responses capture bank data.
    always_comb begin
        wr_rr_d       = wr_go_s ? id_add(wr_gnt_s, 1) : wr_rr_q;
        rd_rr_d       = p_hit_s ? id_add(p_id_s, 1) : rd_rr_q;
        resp0_valid_d = p_hit_s;
        resp0_id_d    = p_hit_s ? p_id_s : resp0_id_q;
        resp0_data_d  = p_hit_s ? rdata_0 : resp0_data_q;
        resp1_valid_d = p1_use_s;
        resp1_id_d    = p1_use_s ? p1_id_s : resp1_id_q;
        resp1_data_d  = p1_use_s ? rdata_1 : resp1_data_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_rr_q       <= '0;
            rd_rr_q       <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_id_q    <= '0;
            resp1_id_q    <= '0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
        end else begin
            wr_rr_q       <= wr_rr_d;
            rd_rr_q       <= rd_rr_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_id_q    <= resp0_id_d;
            resp1_id_q    <= resp1_id_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
        end
    end

    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_id    = resp0_id_q;
    assign resp1_id    = resp1_id_q;
    assign resp0_data  = resp0_data_q;
    assign resp1_data  = resp1_data_q;

endmodule
